pipe_skid_stage: RTL and testbench

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

---
 rtl/pipe_skid_stage_if.sv | 32 +++
 rtl/pipe_skid_stage.sv | 125 ++++++++++++
 tb/tb_pipe_skid_stage.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_skid_stage_if.sv
// Valid/ready handshake bundle for pipe_skid_stage: upstream in_* and downstream out_* channels.
// The stage connects through the slave modport and the driving side uses master.
interface pipe_skid_stage_if #(
  parameter int unsigned WIDTH = 16
) ();

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

endinterface

// File: rtl/pipe_skid_stage.sv
// Two-entry pipeline skid stage with registered in_ready/out_valid/out_data, synchronous flush
// and a saturating count of downstream-stall cycles.
module pipe_skid_stage #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  pipe_skid_stage_if.slave     bus,
  output logic [1:0]           occupancy,
  output logic [CNT_W-1:0]     stall_count
);

  // Bit 0 of the encoding is out_valid, so that output comes straight off the state register.
  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StBusy  = 2'b01,
    StFull  = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic out_valid;
  logic in_fire;
  logic out_fire;

  assign out_valid = state_q[0];
  assign in_fire   = bus.in_valid & in_ready_q;
  assign out_fire  = out_valid & bus.out_ready;

  assign bus.out_valid = out_valid;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_data  = main_q;
  assign stall_count   = stall_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    case (state_q)
      StEmpty: begin
        if (in_fire) begin
          state_d = StBusy;
          main_d  = bus.in_data;
        end
      end
      StBusy: begin
        if (in_fire && out_fire) begin
          main_d = bus.in_data;
        end else if (in_fire) begin
          state_d = StFull;
          skid_d  = bus.in_data;
        end else if (out_fire) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (out_fire) begin
          state_d = StBusy;
          main_d  = skid_q;
        end
      end
      default: begin
        state_d = StEmpty;
      end
    endcase

    // Flush wins over any same-cycle transition; a word leaving this cycle is still delivered.
    if (flush) begin
      state_d = StEmpty;
      main_d  = '0;
      skid_d  = '0;
    end

    in_ready_d = (state_d != StFull);
  end

  always_comb begin
    stall_d = stall_q;
    if (out_valid && !bus.out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_comb begin
    occupancy = 2'd0;
    case (state_q)
      StBusy:  occupancy = 2'd1;
      StFull:  occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StEmpty;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
      stall_q    <= stall_d;
    end
  end

  // in_ready is a separate flop; it must always agree with the state it shadows.
  a_in_ready_tracks_state: assert property (
    @(posedge clk) disable iff (reset) in_ready_q == (state_q != StFull)
  );

  a_state_legal: assert property (
    @(posedge clk) disable iff (reset) state_q inside {StEmpty, StBusy, StFull}
  );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scenario bench for pipe_skid_stage: a queue-based reference model predicts every delivered word,
// occupancy, handshake and stall count.
module tb_pipe_skid_stage;

  localparam int unsigned W = 16;

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic flush  = 1'b0;
  logic flush2 = 1'b0;

  always #5 clk = ~clk;

  pipe_skid_stage_if #(.WIDTH(W)) bus ();
  pipe_skid_stage_if #(.WIDTH(W)) bus2 ();

  logic [1:0] occupancy;
  logic [7:0] stall_count;
  logic [1:0] occupancy2;
  logic [1:0] stall_count2;

  pipe_skid_stage #(.WIDTH(W), .CNT_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .bus         (bus),
    .occupancy   (occupancy),
    .stall_count (stall_count)
  );

  pipe_skid_stage #(.WIDTH(W), .CNT_W(2)) dut_sat (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush2),
    .bus         (bus2),
    .occupancy   (occupancy2),
    .stall_count (stall_count2)
  );

  logic [W-1:0] sb[$];
  int m_occ   = 0;
  int m_stall = 0;
  int n_vec   = 0;
  int n_miss  = 0;

  // One clock of stimulus on dut; advances the model, reports the word leaving this cycle.
  task automatic tick(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl,
                      output logic fired, output logic [W-1:0] exp_w, output logic [W-1:0] seen_w);
    logic m_in_fire;
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    flush         = fl;
    #2;
    m_in_fire = iv && (m_occ != 2);
    fired     = (m_occ != 0) && ordy;
    exp_w     = fired ? sb[0] : '0;
    seen_w    = bus.out_data;
    @(posedge clk);
    if (m_occ != 0 && !ordy && m_stall != 255) m_stall++;
    if (fired) void'(sb.pop_front());
    if (m_in_fire) sb.push_back(d);
    if (fl) sb.delete();
    m_occ = sb.size();
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    m_occ   = 0;
    m_stall = 0;
    reset   = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'hDEAD;
    bus.out_ready = 1'b0;
    flush         = 1'b1;
    bus2.in_valid  = 1'b0;
    bus2.in_data   = '0;
    bus2.out_ready = 1'b1;
    apply_reset();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    n_vec++;
    if ({bus.in_ready, bus.out_valid, occupancy} !== 4'b1000) begin
      n_miss++;
      $display("FAIL reset_flags: got rdy/vld/occ %b required 1000",
               {bus.in_ready, bus.out_valid, occupancy});
    end
    n_vec++;
    if (bus.out_data !== 16'h0000 || stall_count !== 8'd0) begin
      n_miss++;
      $display("FAIL reset_regs: got data %h stall %0d required 0000 0", bus.out_data, stall_count);
    end
  endtask

  task automatic test_streaming();
    logic f;
    logic [W-1:0] e, s;
    for (int i = 1; i <= 16; i++) begin
      tick(1'b1, W'(i), 1'b1, 1'b0, f, e, s);
      if (f) begin
        n_vec++;
        if (s !== e) begin
          n_miss++;
          $display("FAIL stream_deliver[%0d]: got %h required %h", i, s, e);
        end
      end
      n_vec++;
      if (bus.out_data !== W'(i) || occupancy !== 2'd1 || bus.out_valid !== 1'b1) begin
        n_miss++;
        $display("FAIL stream_latency[%0d]: got data %h occ %0d vld %b required %h 1 1",
                 i, bus.out_data, occupancy, bus.out_valid, W'(i));
      end
    end
    tick(1'b0, '0, 1'b1, 1'b0, f, e, s);
    n_vec++;
    if (!f || s !== 16'h0010) begin
      n_miss++;
      $display("FAIL stream_last: got %h required 0010", s);
    end
    n_vec++;
    if (stall_count !== 8'd0 || bus.out_valid !== 1'b0) begin
      n_miss++;
      $display("FAIL stream_end: got stall %0d vld %b required 0 0", stall_count, bus.out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic f;
    logic [W-1:0] e, s;
    tick(1'b1, 16'hAAAA, 1'b0, 1'b0, f, e, s);
    tick(1'b1, 16'hBBBB, 1'b0, 1'b0, f, e, s);
    n_vec++;
    if ({bus.in_ready, bus.out_valid, occupancy} !== 4'b0110 || bus.out_data !== 16'hAAAA) begin
      n_miss++;
      $display("FAIL bp_full: got rdy/vld/occ %b data %h required 0110 aaaa",
               {bus.in_ready, bus.out_valid, occupancy}, bus.out_data);
    end
    tick(1'b1, 16'hCCCC, 1'b0, 1'b0, f, e, s);
    n_vec++;
    if (bus.out_data !== 16'hAAAA || occupancy !== 2'd2) begin
      n_miss++;
      $display("FAIL bp_hold: got data %h occ %0d required aaaa 2", bus.out_data, occupancy);
    end
    tick(1'b0, '0, 1'b1, 1'b0, f, e, s);
    n_vec++;
    if (s !== e || s !== 16'hAAAA) begin
      n_miss++;
      $display("FAIL bp_first: got %h required aaaa", s);
    end
    tick(1'b0, '0, 1'b1, 1'b0, f, e, s);
    n_vec++;
    if (s !== e || s !== 16'hBBBB) begin
      n_miss++;
      $display("FAIL bp_second: got %h required bbbb", s);
    end
    n_vec++;
    if ({bus.in_ready, bus.out_valid, occupancy} !== 4'b1000 || stall_count !== 8'(m_stall)) begin
      n_miss++;
      $display("FAIL bp_empty: got rdy/vld/occ %b stall %0d required 1000 %0d",
               {bus.in_ready, bus.out_valid, occupancy}, stall_count, m_stall);
    end
  endtask

  task automatic test_simultaneous();
    logic f;
    logic [W-1:0] e, s;
    tick(1'b1, 16'h1234, 1'b0, 1'b0, f, e, s);
    tick(1'b1, 16'h5678, 1'b1, 1'b0, f, e, s);
    n_vec++;
    if (s !== 16'h1234 || bus.out_data !== 16'h5678 || occupancy !== 2'd1) begin
      n_miss++;
      $display("FAIL simul: got out %h data %h occ %0d required 1234 5678 1",
               s, bus.out_data, occupancy);
    end
    tick(1'b0, '0, 1'b1, 1'b0, f, e, s);
    n_vec++;
    if (s !== e) begin
      n_miss++;
      $display("FAIL simul_drain: got %h required %h", s, e);
    end
  endtask

  task automatic test_flush();
    logic f;
    logic [W-1:0] e, s;
    tick(1'b1, 16'h1111, 1'b0, 1'b0, f, e, s);
    tick(1'b1, 16'h2222, 1'b0, 1'b0, f, e, s);
    tick(1'b1, 16'h3333, 1'b0, 1'b1, f, e, s);
    n_vec++;
    if ({bus.in_ready, bus.out_valid, occupancy} !== 4'b1000 || bus.out_data !== 16'h0000) begin
      n_miss++;
      $display("FAIL flush_full: got rdy/vld/occ %b data %h required 1000 0000",
               {bus.in_ready, bus.out_valid, occupancy}, bus.out_data);
    end
    n_vec++;
    if (stall_count !== 8'(m_stall)) begin
      n_miss++;
      $display("FAIL flush_stall: got %0d required %0d", stall_count, m_stall);
    end
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, '0, 1'b1, 1'b0, f, e, s);
      n_vec++;
      if (bus.out_valid !== 1'b0) begin
        n_miss++;
        $display("FAIL flush_ghost[%0d]: got vld %b data %h required 0", i, bus.out_valid,
                 bus.out_data);
      end
    end
    tick(1'b1, 16'h4444, 1'b0, 1'b0, f, e, s);
    tick(1'b1, 16'h5555, 1'b1, 1'b1, f, e, s);
    n_vec++;
    if (!f || s !== 16'h4444 || occupancy !== 2'd0 || bus.out_data !== 16'h0000) begin
      n_miss++;
      $display("FAIL flush_deliver: got out %h occ %0d data %h required 4444 0 0000",
               s, occupancy, bus.out_data);
    end
    tick(1'b1, 16'h6666, 1'b1, 1'b0, f, e, s);
    tick(1'b0, '0, 1'b1, 1'b0, f, e, s);
    n_vec++;
    if (s !== e || s !== 16'h6666) begin
      n_miss++;
      $display("FAIL flush_after: got %h required 6666", s);
    end
  endtask

  task automatic test_saturation();
    int exp_cnt;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    flush         = 1'b0;
    bus2.in_valid  = 1'b1;
    bus2.in_data   = 16'h0042;
    bus2.out_ready = 1'b0;
    @(posedge clk);
    #1;
    bus2.in_valid = 1'b0;
    n_vec++;
    if (stall_count2 !== 2'd0 || occupancy2 !== 2'd1) begin
      n_miss++;
      $display("FAIL sat_start: got stall %0d occ %0d required 0 1", stall_count2, occupancy2);
    end
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      exp_cnt = (k < 3) ? k : 3;
      n_vec++;
      if (stall_count2 !== 2'(exp_cnt) || bus2.out_data !== 16'h0042) begin
        n_miss++;
        $display("FAIL sat_count[%0d]: got stall %0d data %h required %0d 0042",
                 k, stall_count2, bus2.out_data, exp_cnt);
      end
    end
    bus2.out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    if (bus2.out_valid !== 1'b0 || stall_count2 !== 2'd3) begin
      n_miss++;
      $display("FAIL sat_drain: got vld %b stall %0d required 0 3", bus2.out_valid, stall_count2);
    end
  endtask

  task automatic test_reset_mid();
    logic f;
    logic [W-1:0] e, s;
    tick(1'b1, 16'h9999, 1'b0, 1'b0, f, e, s);
    tick(1'b1, 16'hA5A5, 1'b0, 1'b0, f, e, s);
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h7E7E;
    bus.out_ready = 1'b1;
    flush         = 1'b1;
    apply_reset();
    n_vec++;
    if ({bus.in_ready, bus.out_valid, occupancy} !== 4'b1000 || bus.out_data !== 16'h0000 ||
        stall_count !== 8'd0) begin
      n_miss++;
      $display("FAIL rstmid_state: got rdy/vld/occ %b data %h stall %0d required 1000 0000 0",
               {bus.in_ready, bus.out_valid, occupancy}, bus.out_data, stall_count);
    end
    tick(1'b1, 16'h7777, 1'b1, 1'b0, f, e, s);
    n_vec++;
    if (bus.out_data !== 16'h7777 || occupancy !== 2'd1) begin
      n_miss++;
      $display("FAIL rstmid_first: got data %h occ %0d required 7777 1", bus.out_data, occupancy);
    end
    tick(1'b0, '0, 1'b1, 1'b0, f, e, s);
    n_vec++;
    if (s !== 16'h7777 || bus.out_valid !== 1'b0) begin
      n_miss++;
      $display("FAIL rstmid_after: got out %h vld %b required 7777 0", s, bus.out_valid);
    end
  endtask

  task automatic test_random();
    logic f, iv, ordy, fl;
    logic [W-1:0] d, e, s;
    for (int i = 0; i < 300; i++) begin
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 31) == 0);
      d    = W'($urandom);
      tick(iv, d, ordy, fl, f, e, s);
      if (f) begin
        n_vec++;
        if (s !== e) begin
          n_miss++;
          $display("FAIL rand_deliver[%0d]: got %h required %h", i, s, e);
        end
      end
      n_vec++;
      if ({bus.in_ready, bus.out_valid, occupancy} !==
          {m_occ != 2, m_occ != 0, 2'(m_occ)} || stall_count !== 8'(m_stall)) begin
        n_miss++;
        $display("FAIL rand_state[%0d]: got rdy/vld/occ %b stall %0d required occ %0d stall %0d",
                 i, {bus.in_ready, bus.out_valid, occupancy}, stall_count, m_occ, m_stall);
      end
      if (m_occ != 0 || fl) begin
        n_vec++;
        if (bus.out_data !== ((m_occ != 0) ? sb[0] : 16'h0000)) begin
          n_miss++;
          $display("FAIL rand_head[%0d]: got %h", i, bus.out_data);
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, '0, 1'b1, 1'b0, f, e, s);
      if (f) begin
        n_vec++;
        if (s !== e) begin
          n_miss++;
          $display("FAIL rand_drain[%0d]: got %h required %h", i, s, e);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_simultaneous();
    test_flush();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
